// File: rtl/trace_pkg.sv
// trace_pkg: state encodings, mode constants and count-width helper shared by the trace buffer.
package trace_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;
    localparam logic MODE_START = 1'b0;
    localparam logic MODE_STOP  = 1'b1;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: unreset flop array with one synchronous write port and one asynchronous read port.
module trace_ram #(
    parameter int W     = 48,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/trace_capture.sv
// trace_capture: captures a window of {addr,data} samples around a trigger and streams it out oldest-first.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              mode,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [CNT_W-1:0]  post_cnt,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] sample_addr,
    input  logic [DATA_W-1:0] sample_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  count,
    output logic              triggered
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic               trig_q, trig_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic               we;
    logic               hit;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   post_lim;
    logic [PTR_W-1:0]   rd_idx;
    logic [ADDR_W+DATA_W-1:0] rd_word;

    assign hit       = sample_valid && (!trig_en || sample_addr == trig_addr);
    assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + CNT_W'(1);
    assign post_lim  = (post_cnt > MAX_POST) ? MAX_POST : post_cnt;
    // Oldest entry trails the write pointer by count; at count==DEPTH the low bits wrap to wr_ptr itself.
    assign rd_idx    = wr_ptr_q - count_q[PTR_W-1:0];
    assign rd_valid  = (state_q == DONE) && (count_q != '0);
    assign rd_addr   = rd_valid ? rd_word[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign rd_data   = rd_valid ? rd_word[DATA_W-1:0] : '0;
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = trig_q;

    trace_ram #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata ({sample_addr, sample_data}),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_START;
            trig_q   <= 1'b0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            trig_q   <= trig_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        trig_d   = trig_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        we       = 1'b0;
        if (arm) begin
            state_d  = ARMED;
            mode_d   = mode;
            trig_d   = 1'b0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    we = (mode_q == MODE_STOP) ? sample_valid : hit;
                    if (hit) begin
                        trig_d  = 1'b1;
                        post_d  = post_lim;
                        state_d = (mode_q == MODE_STOP && post_lim == '0) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    we = sample_valid;
                    if (sample_valid && mode_q == MODE_START) begin
                        state_d = (count_inc == DEPTH_C) ? DONE : CAPTURE;
                    end else if (sample_valid) begin
                        post_d  = post_q - CNT_W'(1);
                        state_d = (post_q == CNT_W'(1)) ? DONE : CAPTURE;
                    end
                end
                DONE: begin
                    if (rd_valid && rd_ready) begin
                        count_d = count_q - CNT_W'(1);
                        state_d = (count_q == CNT_W'(1)) ? IDLE : DONE;
                    end
                end
                default: ;
            endcase
            if (we) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_inc;
            end
        end
    end
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed and randomized capture windows checked against a window-level model.
module tb_trace_capture;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          mode = 1'b0;
    logic          trig_en = 1'b0;
    logic [AW-1:0] trig_addr = '0;
    logic [CW-1:0] post_cnt = '0;
    logic          sample_valid = 1'b0;
    logic [AW-1:0] sample_addr = '0;
    logic [DW-1:0] sample_data = '0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          triggered;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic          sv[$];
    logic [AW-1:0] sa[$];
    logic [DW-1:0] sd[$];

    trace_capture #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode), .trig_en(trig_en),
        .trig_addr(trig_addr), .post_cnt(post_cnt), .sample_valid(sample_valid),
        .sample_addr(sample_addr), .sample_data(sample_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data), .state(state),
        .count(count), .triggered(triggered)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sample_valid = v;
        sample_addr  = a;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm(input logic m);
        arm = 1'b1;
        mode = m;
        sample_valid = 1'b0;
        tick();
        arm = 1'b0;
        checks++;
        if (state !== 2'd1 || count !== '0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL arm: got state=%0d count=%0d trig=%0b expected 1 0 0", state, count, triggered);
        end
    endtask

    task automatic drive_stream();
        foreach (sv[i]) drive(sv[i], sa[i], sd[i]);
    endtask

    // Window model: mode 0 keeps the trigger and the next D-1 valid samples; mode 1 keeps
    // up to D-1-p samples before the trigger, the trigger, and p samples after it.
    task automatic build_model(input logic m, input logic te, input logic [AW-1:0] ta, input int p);
        int vi[$];
        int ti;
        int lo;
        int hi;
        int pp;
        exp_a.delete();
        exp_d.delete();
        ti = -1;
        foreach (sv[i]) begin
            if (sv[i]) begin
                if (ti < 0 && (!te || sa[i] == ta)) ti = vi.size();
                vi.push_back(i);
            end
        end
        pp = (p > D - 1) ? D - 1 : p;
        lo = m ? ti - (D - 1 - pp) : ti;
        if (lo < 0) lo = 0;
        hi = m ? ti + pp : ti + D - 1;
        for (int k = lo; k <= hi && k < vi.size(); k++) begin
            exp_a.push_back(sa[vi[k]]);
            exp_d.push_back(sd[vi[k]]);
        end
    endtask

    task automatic check_done(input string name);
        checks++;
        if (state !== 2'd3 || triggered !== 1'b1 || count !== CW'(exp_a.size())) begin
            errors++;
            $display("FAIL %s_done: got state=%0d trig=%0b count=%0d expected 3 1 %0d",
                     name, state, triggered, count, exp_a.size());
        end
    endtask

    task automatic readout(input string name);
        int guard;
        logic took;
        guard = 0;
        while (exp_a.size() > 0 && guard < 100) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_a[0] || rd_data !== exp_d[0] || count !== CW'(exp_a.size())) begin
                errors++;
                $display("FAIL %s_rd: got v=%0b a=%h d=%h cnt=%0d expected v=1 a=%h d=%h cnt=%0d",
                         name, rd_valid, rd_addr, rd_data, count, exp_a[0], exp_d[0], exp_a.size());
            end
            took = 1'($urandom_range(0, 1));
            rd_ready = took;
            tick();
            if (took) begin
                void'(exp_a.pop_front());
                void'(exp_d.pop_front());
            end
            guard++;
        end
        rd_ready = 1'b0;
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_a.size());
        end
        checks++;
        if (rd_valid !== 1'b0 || state !== 2'd0 || rd_addr !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL %s_end: got v=%0b state=%0d a=%h d=%h expected 0 0 0 0",
                     name, rd_valid, state, rd_addr, rd_data);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || triggered !== 1'b0 || rd_addr !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset: got state=%0d count=%0d v=%0b trig=%0b a=%h d=%h expected all 0",
                     state, count, rd_valid, triggered, rd_addr, rd_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || count !== '0) begin
            errors++;
            $display("FAIL reset_idle: got state=%0d count=%0d expected 0 0", state, count);
        end
    endtask

    task automatic test_mode0_full();
        trig_en = 1'b1;
        trig_addr = 16'h0004;
        do_arm(1'b0);
        drive(1'b1, 16'd0, 32'd3);
        checks++;
        if (state !== 2'd1 || triggered !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL m0_pre: got state=%0d trig=%0b count=%0d expected 1 0 0", state, triggered, count);
        end
        drive(1'b1, 16'd4, 32'd6);
        checks++;
        if (state !== 2'd2 || triggered !== 1'b1 || count !== CW'(1)) begin
            errors++;
            $display("FAIL m0_trig: got state=%0d trig=%0b count=%0d expected 2 1 1", state, triggered, count);
        end
        drive(1'b1, 16'd8, 32'd8);
        drive(1'b1, 16'd12, 32'd10);
        drive(1'b1, 16'd16, 32'd12);
        exp_a = '{16'd4, 16'd8, 16'd12, 16'd16};
        exp_d = '{32'd6, 32'd8, 32'd10, 32'd12};
        check_done("m0");
        readout("m0");
    endtask

    task automatic test_mode1_backpressure();
        trig_en = 1'b1;
        trig_addr = 16'h000C;
        post_cnt = CW'(1);
        do_arm(1'b1);
        for (int a = 0; a <= 20; a += 4) drive(1'b1, AW'(a), DW'(a + 1));
        exp_a = '{16'd4, 16'd8, 16'd12, 16'd16};
        exp_d = '{32'd5, 32'd9, 32'd13, 32'd17};
        check_done("m1");
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_addr !== 16'd4 || rd_data !== 32'd5 || count !== CW'(4) || state !== 2'd3) begin
                errors++;
                $display("FAIL hold: got v=%0b a=%h d=%h cnt=%0d state=%0d expected 1 0004 00000005 4 3",
                         rd_valid, rd_addr, rd_data, count, state);
            end
        end
        readout("m1");
    endtask

    task automatic test_post_zero();
        trig_en = 1'b1;
        trig_addr = 16'h000C;
        post_cnt = '0;
        do_arm(1'b1);
        drive(1'b1, 16'd0, 32'd100);
        drive(1'b1, 16'd4, 32'd104);
        drive(1'b1, 16'd8, 32'd108);
        drive(1'b1, 16'd12, 32'd112);
        exp_a = '{16'd0, 16'd4, 16'd8, 16'd12};
        exp_d = '{32'd100, 32'd104, 32'd108, 32'd112};
        check_done("p0");
        drive(1'b1, 16'd16, 32'd116);
        readout("p0");
    endtask

    task automatic test_rearm();
        trig_en = 1'b1;
        trig_addr = 16'h0020;
        do_arm(1'b0);
        drive(1'b1, 16'h0020, 32'hA);
        drive(1'b1, 16'h0024, 32'hB);
        checks++;
        if (state !== 2'd2 || count !== CW'(2)) begin
            errors++;
            $display("FAIL rearm_pre: got state=%0d count=%0d expected 2 2", state, count);
        end
        arm = 1'b1;
        mode = 1'b0;
        sample_valid = 1'b1;
        sample_addr = 16'h0020;
        sample_data = 32'hC;
        tick();
        arm = 1'b0;
        sample_valid = 1'b0;
        checks++;
        if (state !== 2'd1 || count !== '0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL rearm: got state=%0d count=%0d trig=%0b expected 1 0 0", state, count, triggered);
        end
        tick();
        checks++;
        if (state !== 2'd1 || count !== '0) begin
            errors++;
            $display("FAIL rearm_idle: got state=%0d count=%0d expected 1 0", state, count);
        end
    endtask

    task automatic test_async_reset();
        trig_en = 1'b0;
        do_arm(1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), DW'(i));
        checks++;
        if (state !== 2'd3 || count !== CW'(4)) begin
            errors++;
            $display("FAIL ar_pre: got state=%0d count=%0d expected 3 4", state, count);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d count=%0d v=%0b trig=%0b expected 0 0 0 0",
                     state, count, rd_valid, triggered);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic m;
            logic te;
            int p;
            int npre;
            m = 1'($urandom_range(0, 1));
            te = ($urandom_range(0, 3) != 0);
            p = $urandom_range(0, 7);
            npre = $urandom_range(0, 7);
            trig_en = te;
            trig_addr = 16'h0040;
            post_cnt = CW'(p);
            sv.delete();
            sa.delete();
            sd.delete();
            for (int i = 0; i < npre; i++) begin
                sv.push_back(1'($urandom_range(0, 1)));
                sa.push_back(AW'($urandom_range(16'h0100, 16'h01FF)));
                sd.push_back($urandom);
            end
            sv.push_back(1'b1);
            sa.push_back(16'h0040);
            sd.push_back($urandom);
            for (int i = 0; i < 12; i++) begin
                sv.push_back((i % 2 == 0) || ($urandom_range(0, 1) == 1));
                sa.push_back(AW'($urandom_range(16'h0000, 16'h0080)));
                sd.push_back($urandom);
            end
            build_model(m, te, 16'h0040, p);
            do_arm(m);
            drive_stream();
            check_done("rnd");
            readout("rnd");
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mode0_full();
        test_mode1_backpressure();
        test_post_zero();
        test_rearm();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
